// File: rtl/mac_engine_mc.sv
// Multi-lane MAC engine: joined a/b/c input streams, MULADD or per-lane ACCUM, one d stream.
// Optional feature: define MAC_ENGINE_MC_SAT_EN to saturate (rather than wrap) the reduction to DW.
module mac_engine_mc #(
  parameter int N_LANES   = 2,
  parameter int DW        = 16,
  parameter int LEN_W     = 16,
  parameter int ACC_GUARD = 8,
  localparam int ACC_W    = 2*DW + ACC_GUARD,
  localparam int SH_W     = $clog2(ACC_W)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic [SH_W-1:0]       shift_i,
  input  logic                  mode_i,
  input  logic [N_LANES*DW-1:0] a_data_i,
  input  logic [N_LANES*DW-1:0] b_data_i,
  input  logic [N_LANES*DW-1:0] c_data_i,
  input  logic                  a_valid_i,
  input  logic                  b_valid_i,
  input  logic                  c_valid_i,
  output logic                  a_ready_o,
  output logic                  b_ready_o,
  output logic                  c_ready_o,
  output logic [N_LANES*DW-1:0] d_data_o,
  output logic                  d_valid_o,
  input  logic                  d_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LEN_W-1:0]      cnt_o,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, cnt_q;
  logic [SH_W-1:0]   shift_q;
  logic              mode_q;
  logic              en, fire, last_fire, pipe_empty;
  logic              s1_valid, s1_last, s2_last;

  logic signed [2*DW-1:0]  s1_p   [N_LANES];
  logic signed [DW-1:0]    s1_c   [N_LANES];
  logic signed [ACC_W-1:0] acc    [N_LANES];
  logic signed [2*DW-1:0]  a_x    [N_LANES];
  logic signed [2*DW-1:0]  b_x    [N_LANES];
  logic signed [ACC_W-1:0] sum_x  [N_LANES];
  logic signed [ACC_W-1:0] acc_sh [N_LANES];

`ifdef MAC_ENGINE_MC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic [DW-1:0] reduce(input logic signed [ACC_W-1:0] x);
    if (x > SAT_MAX) return SAT_MAX[DW-1:0];
    else if (x < SAT_MIN) return SAT_MIN[DW-1:0];
    return x[DW-1:0];
  endfunction
`else
  function automatic logic [DW-1:0] reduce(input logic signed [ACC_W-1:0] x);
    return DW'(x);
  endfunction
`endif

  // Lane arithmetic. The MULADD sum is formed at ACC_W bits, which is at least
  // the exact 2*DW+1 bits needed, so the result never overflows before reduction.
  always_comb begin
    for (int k = 0; k < N_LANES; k++) begin
      a_x[k]    = (2*DW)'($signed(a_data_i[k*DW +: DW]));
      b_x[k]    = (2*DW)'($signed(b_data_i[k*DW +: DW]));
      sum_x[k]  = ACC_W'(s1_p[k] >>> shift_q) + ACC_W'(s1_c[k]);
      acc_sh[k] = acc[k] >>> shift_q;
    end
  end

  // Valid/ready: a beat transfers on a cycle where valid and ready are both high.
  // a and b (plus c in MULADD) are joined and transfer together; their readies
  // depend combinationally on the valids, while d_valid_o/d_data_o are registered.
  always_comb begin
    state_d    = state_q;
    en         = !d_valid_o || d_ready_i;
    fire       = (state_q == RUN) && (cnt_q < len_q) && en &&
                 a_valid_i && b_valid_i && (c_valid_i || mode_q);
    last_fire  = fire && ((cnt_q + LEN_W'(1)) == len_q);
    a_ready_o  = fire;
    b_ready_o  = fire;
    c_ready_o  = fire && !mode_q;
    busy_o     = (state_q != IDLE);
    done_o     = (state_q == DONE);
    pipe_empty = !s1_valid && !s2_last;
    unique case (state_q)
      // A zero-length job drains through an already-empty FLUSH so done lands two cycles after start.
      IDLE:  if (start_i) state_d = (len_i == '0) ? FLUSH : RUN;
      RUN:   if (last_fire) state_d = FLUSH;
      FLUSH: if (pipe_empty && (!d_valid_o || d_ready_i)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_q     <= '0;
      shift_q   <= '0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s2_last   <= 1'b0;
      d_valid_o <= 1'b0;
      d_data_o  <= '0;
      for (int k = 0; k < N_LANES; k++) begin
        s1_p[k] <= '0;
        s1_c[k] <= '0;
        acc[k]  <= '0;
      end
    end else begin
      if (state_q == IDLE && start_i) begin
        len_q   <= len_i;
        shift_q <= shift_i;
        mode_q  <= mode_i;
        cnt_q   <= '0;
        for (int k = 0; k < N_LANES; k++) acc[k] <= '0;
      end
      if (fire) cnt_q <= cnt_q + LEN_W'(1);
      if (en) begin
        s1_valid <= fire;
        s1_last  <= last_fire;
        if (fire) begin
          for (int k = 0; k < N_LANES; k++) begin
            s1_p[k] <= a_x[k] * b_x[k];
            s1_c[k] <= $signed(c_data_i[k*DW +: DW]);
          end
        end
        if (mode_q) begin
          // ACCUM: stage 2 accumulates, a third stage emits the single shifted result.
          s2_last   <= s1_valid && s1_last;
          d_valid_o <= s2_last;
          for (int k = 0; k < N_LANES; k++) begin
            if (s1_valid) acc[k] <= acc[k] + ACC_W'(s1_p[k]);
            if (s2_last)  d_data_o[k*DW +: DW] <= reduce(acc_sh[k]);
          end
        end else begin
          s2_last   <= 1'b0;
          d_valid_o <= s1_valid;
          for (int k = 0; k < N_LANES; k++) begin
            if (s1_valid) d_data_o[k*DW +: DW] <= reduce(sum_x[k]);
          end
        end
      end
    end
  end

  assign cnt_o       = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mac_engine_mc.sv
// Directed bench for mac_engine_mc: vector table of single-beat MULADD jobs plus
// hand-written job sequences for latency, ACCUM, backpressure, len=0, start-while-busy and reset abort.
module tb_mac_engine_mc;
  localparam int N_LANES = 2;
  localparam int DW      = 16;
  localparam int LEN_W   = 16;
  localparam int SH_W    = 6;
  localparam int W       = N_LANES*DW;
`ifdef MAC_ENGINE_MC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_i, start_i, mode_i;
  logic [LEN_W-1:0] len_i;
  logic [SH_W-1:0]  shift_i;
  logic [W-1:0]     a_data_i, b_data_i, c_data_i;
  logic             a_valid_i, b_valid_i, c_valid_i;
  logic             a_ready_o, b_ready_o, c_ready_o;
  logic [W-1:0]     d_data_o;
  logic             d_valid_o, d_ready_i;
  logic             busy_o, done_o;
  logic [LEN_W-1:0] cnt_o;
  logic [1:0]       dbg_state_o;

  mac_engine_mc dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .shift_i(shift_i),
    .mode_i(mode_i), .a_data_i(a_data_i), .b_data_i(b_data_i), .c_data_i(c_data_i),
    .a_valid_i(a_valid_i), .b_valid_i(b_valid_i), .c_valid_i(c_valid_i),
    .a_ready_o(a_ready_o), .b_ready_o(b_ready_o), .c_ready_o(c_ready_o),
    .d_data_o(d_data_o), .d_valid_o(d_valid_o), .d_ready_i(d_ready_i),
    .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  typedef struct {
    logic [SH_W-1:0] shift;
    logic [W-1:0]    a, b, c, exp_t, exp_s;
  } vec_t;

  vec_t         vecs[7];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] beat_a[$], beat_b[$], beat_c[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0;
  int hs_count, last_hs_cyc, first_v_cyc, done_cyc, done_count, n_fire, last_fire_cyc;
  bit fired, c_ready_seen, prev_stall, bp_en;
  int bp_i;
  logic [3:0]   bp_pat = 4'b1001;
  logic [W-1:0] prev_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor, one clock per call ----------------
  task automatic tick();
    logic [W-1:0] e;
    d_ready_i = bp_en ? bp_pat[bp_i % 4] : 1'b1;
    if (bp_en) bp_i++;
    @(negedge clk);
    if (d_valid_o && d_ready_i) begin
      hs_count++;
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL d_unexpected: got 0x%0h expected no beat", d_data_o);
      end else begin
        e = exp_q.pop_front();
        check("d_data", d_data_o, e);
      end
    end
    if (d_valid_o && first_v_cyc < 0) first_v_cyc = cyc;
    if (prev_stall) begin
      check("stall_valid", d_valid_o, 1);
      check("stall_data", d_data_o, prev_data);
    end
    if (d_valid_o && !d_ready_i) check("ready_in_stall", {a_ready_o, b_ready_o, c_ready_o}, 0);
    prev_stall = d_valid_o && !d_ready_i;
    prev_data  = d_data_o;
    if (c_ready_o) c_ready_seen = 1'b1;
    if (done_o) begin
      done_count++;
      done_cyc = cyc;
    end
    fired = a_valid_i && a_ready_o;
    if (fired) begin
      n_fire++;
      last_fire_cyc = cyc;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic reset_job();
    hs_count = 0; last_hs_cyc = -1; first_v_cyc = -1; done_cyc = -1;
    done_count = 0; n_fire = 0; last_fire_cyc = -1; c_ready_seen = 1'b0;
    beat_a.delete(); beat_b.delete(); beat_c.delete();
  endtask

  task automatic push_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    beat_a.push_back(a); beat_b.push_back(b); beat_c.push_back(c);
  endtask

  task automatic start_job(input logic mode, input int len, input int shift);
    mode_i = mode; len_i = LEN_W'(len); shift_i = SH_W'(shift);
    start_i = 1'b1;
    start_cyc = cyc;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_stream(input int len, input bit use_c, input int budget);
    int idx = 0;
    int k = 0;
    a_valid_i = 1'b1; b_valid_i = 1'b1; c_valid_i = use_c;
    while (idx < len && k < budget) begin
      a_data_i = beat_a[idx]; b_data_i = beat_b[idx]; c_data_i = beat_c[idx];
      tick();
      if (fired) idx++;
      k++;
    end
    a_valid_i = 1'b0; b_valid_i = 1'b0; c_valid_i = 1'b0;
    if (idx < len) check("stream_timeout", idx, len);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_count == 0 && k < budget) begin
      tick();
      k++;
    end
    check("done_seen", done_count, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{shift: 6'd0,  a: 32'h0003_0003, b: 32'hFFFB_FFFB, c: 32'h0007_0007, exp_t: 32'hFFF8_FFF8, exp_s: 32'hFFF8_FFF8};
    vecs[1] = '{shift: 6'd4,  a: 32'hFF9C_0064, b: 32'h00C8_00C8, c: 32'h0000_FFFF, exp_t: 32'hFB1E_04E1, exp_s: 32'hFB1E_04E1};
    vecs[2] = '{shift: 6'd15, a: 32'h8000_7FFF, b: 32'h8000_7FFF, c: 32'h0000_0001, exp_t: 32'h8000_7FFF, exp_s: 32'h7FFF_7FFF};
    vecs[3] = '{shift: 6'd0,  a: 32'h7FFF_7FFF, b: 32'h7FFF_8000, c: 32'h7FFF_8000, exp_t: 32'h8000_0000, exp_s: 32'h7FFF_8000};
    vecs[4] = '{shift: 6'd0,  a: 32'h0000_FFFF, b: 32'h04D2_FFFF, c: 32'h1234_FFFE, exp_t: 32'h1234_FFFF, exp_s: 32'h1234_FFFF};
    vecs[5] = '{shift: 6'd31, a: 32'h0001_8000, b: 32'h0001_7FFF, c: 32'h0005_0000, exp_t: 32'h0005_FFFF, exp_s: 32'h0005_FFFF};
    vecs[6] = '{shift: 6'd1,  a: 32'h0007_FFFD, b: 32'h0001_0005, c: 32'h0000_0000, exp_t: 32'h0003_FFF8, exp_s: 32'h0003_FFF8};

    rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; len_i = '0; shift_i = '0;
    a_data_i = '0; b_data_i = '0; c_data_i = '0;
    a_valid_i = 1'b0; b_valid_i = 1'b0; c_valid_i = 1'b0; d_ready_i = 1'b1;
    bp_en = 1'b0; bp_i = 0; prev_stall = 1'b0; prev_data = '0;
    reset_job();
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;

    // reset values
    check("reset_readies", {a_ready_o, b_ready_o, c_ready_o}, 0);
    check("reset_d_valid", d_valid_o, 0);
    check("reset_d_data", d_data_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_cnt", cnt_o, 0);
    check("reset_state", dbg_state_o, 0);

    // table: one single-beat MULADD job per vector
    for (int i = 0; i < 7; i++) begin
      reset_job();
      push_beat(vecs[i].a, vecs[i].b, vecs[i].c);
      exp_q.push_back(SAT ? vecs[i].exp_s : vecs[i].exp_t);
      start_job(1'b0, 1, int'(vecs[i].shift));
      run_stream(1, 1'b1, 20);
      wait_done(20);
      check($sformatf("vec%0d_beats", i), hs_count, 1);
    end

    // MULADD len=4: latency, throughput, done timing, count
    reset_job();
    for (int i = 0; i < 4; i++) begin
      push_beat(32'h0003_0003, 32'hFFFB_FFFB, 32'h0007_0007);
      exp_q.push_back(32'hFFF8_FFF8);
    end
    start_job(1'b0, 4, 0);
    check("muladd_busy_t1", busy_o, 1);
    check("muladd_cnt_clear", cnt_o, 0);
    run_stream(4, 1'b1, 50);
    wait_done(50);
    check("muladd_first_valid", first_v_cyc, start_cyc + 3);
    check("muladd_done_cyc", done_cyc, start_cyc + 7);
    check("muladd_done_after_hs", done_cyc, last_hs_cyc + 1);
    check("muladd_beats", hs_count, 4);
    check("muladd_cnt", cnt_o, 4);
    tick();
    check("muladd_done_pulse", done_count, 1);
    check("muladd_cnt_hold", cnt_o, 4);

    // ACCUM len=8 shift=2, c never valid
    reset_job();
    for (int i = 0; i < 8; i++) push_beat(32'h0002_0001, 32'h0004_0004, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0010_0008);
    start_job(1'b1, 8, 2);
    run_stream(8, 1'b0, 50);
    wait_done(50);
    check("accum_c_ready", c_ready_seen, 0);
    check("accum_beats", hs_count, 1);
    check("accum_latency", first_v_cyc, last_fire_cyc + 3);
    check("accum_first_valid", first_v_cyc, start_cyc + 11);
    check("accum_done_after_hs", done_cyc, last_hs_cyc + 1);
    check("accum_cnt", cnt_o, 8);

    // MULADD len=6 with d_ready pattern 1-0-0-1
    reset_job();
    for (int i = 0; i < 6; i++) begin
      push_beat({16'(-(i + 2)), 16'(i + 1)}, {16'd5, 16'd3}, {16'd100, 16'(i)});
      exp_q.push_back({16'(90 - 5*i), 16'(4*i + 3)});
    end
    bp_en = 1'b1; bp_i = 0;
    start_job(1'b0, 6, 0);
    run_stream(6, 1'b1, 100);
    wait_done(100);
    bp_en = 1'b0;
    check("bp_beats", hs_count, 6);
    check("bp_queue_empty", exp_q.size(), 0);
    check("bp_cnt", cnt_o, 6);
    check("bp_done_after_hs", done_cyc, last_hs_cyc + 1);

    // len=0
    reset_job();
    start_job(1'b0, 0, 0);
    check("len0_busy", busy_o, 1);
    wait_done(10);
    check("len0_done_cyc", done_cyc, start_cyc + 2);
    check("len0_beats", hs_count, 0);
    check("len0_fires", n_fire, 0);
    check("len0_cnt", cnt_o, 0);

    // start_i while busy is ignored
    reset_job();
    for (int i = 0; i < 3; i++) begin
      push_beat(32'h0003_0003, 32'hFFFB_FFFB, 32'h0007_0007);
      exp_q.push_back(32'hFFF8_FFF8);
    end
    start_job(1'b0, 3, 0);
    mode_i = 1'b1; len_i = 16'd9; start_i = 1'b1;
    tick();
    start_i = 1'b0; mode_i = 1'b0;
    run_stream(3, 1'b1, 30);
    wait_done(30);
    check("busy_start_beats", hs_count, 3);
    check("busy_start_cnt", cnt_o, 3);
    check("busy_start_done", done_count, 1);

    // reset mid-ACCUM after 3 beats, then fresh jobs
    reset_job();
    for (int i = 0; i < 8; i++) push_beat(32'h0001_0001, 32'h0001_0001, 32'h0);
    start_job(1'b1, 8, 0);
    run_stream(3, 1'b0, 30);
    a_valid_i = 1'b1; b_valid_i = 1'b1; c_valid_i = 1'b1;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("abort_readies", {a_ready_o, b_ready_o, c_ready_o}, 0);
    check("abort_d_valid", d_valid_o, 0);
    check("abort_d_data", d_data_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_cnt", cnt_o, 0);
    a_valid_i = 1'b0; b_valid_i = 1'b0; c_valid_i = 1'b0;
    reset_job();
    repeat (6) tick();
    check("abort_no_beat", hs_count, 0);
    check("abort_no_done", done_count, 0);

    reset_job();
    for (int i = 0; i < 2; i++) push_beat(32'h0001_0001, 32'h0001_0001, 32'h0);
    exp_q.push_back(32'h0002_0002);
    start_job(1'b1, 2, 0);
    run_stream(2, 1'b0, 20);
    wait_done(30);
    check("post_abort_beats", hs_count, 1);

    reset_job();
    push_beat(32'h0001_0001, 32'h0001_0001, 32'h0);
    exp_q.push_back(32'h0001_0001);
    start_job(1'b1, 1, 0);
    run_stream(1, 1'b0, 20);
    wait_done(30);
    check("acc_clear_beats", hs_count, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
